key_bounce_gen: RTL and testbench
=================================

# key_bounce_gen

Synthesizable key-press emulator. It drives the line that the key debouncer consumes: a press request with a hold time produces an active-low key waveform with pseudo-random contact bounce on both press and release edges. Used for on-board self-test of the debounce path and for closed-loop benches of the key front end.

## Interface
- `BOUNCE_CYC`, 500_000: bounce window length in clk cycles, applied at both press and release; must be ≥ 2.
- `GAP_W`, 12: width of the random inter-toggle gap field; each gap is 1 + lfsr[GAP_W-1:0] cycles.
- `HOLD_W`, 24: width of `req_hold`.
- `SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports (clock and reset first):
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  press request.
- `req_ready`  out  1  high only in IDLE; the request is accepted on a `clk` edge where `req_valid & req_ready`.
- `req_hold`  in  HOLD_W  stable-low hold length in cycles; sampled at acceptance.
- `key_out`  out  1  emulated key line; idle high, pressed low.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a press/release sequence completes.

## Operation
- Reset values: `key_out`=1, `req_ready`=1, `busy`=0, `done`=0, state IDLE, LFSR=SEED.
- States: IDLE → PRESS → HOLD → RELEASE → IDLE.
- IDLE: `key_out`=1. On acceptance, latch H = max(`req_hold`, 1) and go to PRESS. `req_valid` is ignored while busy.
- PRESS (BOUNCE_CYC cycles): the first cycle drives `key_out`=0 and loads the gap counter. When the gap counter expires before the last window cycle, `key_out` inverts and the gap counter reloads. The last window cycle forces `key_out`=0. Then go to HOLD.
- HOLD (H cycles): `key_out`=0 steady, with no toggles.
- RELEASE (BOUNCE_CYC cycles): mirror of PRESS. The first cycle drives `key_out`=1 and the last cycle forces `key_out`=1.
- Return to IDLE with `done`=1 for exactly that first IDLE cycle. `req_ready`=1 in the same cycle, so a back-to-back request can be accepted there.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle regardless of state. A gap reload uses the current value.
- Window counter width: $clog2(BOUNCE_CYC+1). Gap counter width: GAP_W+1. Neither counter wraps; both reload.
- Reset mid-operation: the next edge returns IDLE values, `key_out`=1, no `done`, and the latched H is discarded.

## Timing
- Acceptance at edge T: the state is PRESS and `key_out`=0 from T+1.
- `key_out`=0 guaranteed from T+BOUNCE_CYC through T+BOUNCE_CYC+H.
- RELEASE starts at T+BOUNCE_CYC+H+1 with `key_out`=1.
- `done` is asserted in cycle T+2·BOUNCE_CYC+H+1.
- Back-to-back requests: `done`-to-`done` spacing is 2·BOUNCE_CYC+H+1.
- The minimum spacing between bounce toggles is 1 cycle; the maximum is 2^GAP_W cycles.

## Configuration
- `KEY_BOUNCE_EN` defined: bounce toggles are generated as described above.
- `KEY_BOUNCE_EN` undefined:
  - the LFSR and gap counter are removed;
  - PRESS/RELEASE still last BOUNCE_CYC cycles, so timing is identical, but `key_out` holds its final value (0 or 1) for the whole window;
  - the sequence is exactly one falling edge and one rising edge.

## Structure
- Shared package `key_pkg`:
  - state enum (IDLE, PRESS, HOLD, RELEASE);
  - LFSR width and tap mask constant;
  - key polarity constants KEY_IDLE=1, KEY_PRESSED=0, shared with the debouncer.
- Sub-module `lfsr16` (clk, rst, seed param, q[15:0]), compiled only under `KEY_BOUNCE_EN`.

## Test plan
- Reset: `rst`=1 for 3 cycles, with `req_valid`=1 → `key_out`=1, `req_ready`=1, `busy`=0, `done`=0; no acceptance while `rst` is high.
- BOUNCE_CYC=100, `req_hold`=50, accept at T → `key_out`=0 at T+1; `key_out`=0 for all of T+100..T+150; `done` at T+251 with `key_out`=1.
- `req_hold`=0, BOUNCE_CYC=100 → HOLD lasts 1 cycle; `done` at T+202.
- `req_valid` held high, `req_hold`=50, BOUNCE_CYC=100 → second acceptance in the `done` cycle; second `done` exactly 251 cycles after the first; `req_valid` while busy causes no effect.
- `rst` pulsed 1 cycle in the middle of HOLD → next cycle `key_out`=1, `req_ready`=1, `busy`=0; no `done` ever.
- GAP_W=4, BOUNCE_CYC=100, SEED=16'hACE1:
  - with `KEY_BOUNCE_EN`: ≥3 extra `key_out` edges in each window, and the debouncer (filter > 100 cycles) reports exactly one press and one release;
  - without `KEY_BOUNCE_EN`: exactly 2 edges.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the key emulator and the debouncer it feeds.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } key_state_t;

    localparam int                LFSR_W    = 16;
    // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic KEY_IDLE    = 1'b1;
    localparam logic KEY_PRESSED = 1'b0;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR that feeds the bounce gap generator.
// Only built when KEY_BOUNCE_EN is defined.
`ifdef KEY_BOUNCE_EN
module lfsr16
    import key_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? 16'h0001 : SEED;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED_NZ;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule
`endif

// File: rtl/key_bounce_gen.sv
// Key-press emulator: turns a press request into an active-low key waveform.
// Define KEY_BOUNCE_EN to add pseudo-random contact bounce in the press/release windows.
module key_bounce_gen
    import key_pkg::*;
#(
    parameter int          BOUNCE_CYC = 500_000,
    parameter int          GAP_W      = 12,
    parameter int          HOLD_W     = 24,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              key_out,
    output logic              busy,
    output logic              done
);

    localparam int               WIN_W    = $clog2(BOUNCE_CYC + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BOUNCE_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_PEN  = WIN_W'(BOUNCE_CYC - 2);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    key_state_t        state_q, state_d;
    logic              key_q, key_d;
    logic              done_q, done_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              win_level;

`ifdef KEY_BOUNCE_EN
    localparam logic [GAP_W:0] GAP_ONE = (GAP_W + 1)'(1);

    logic [LFSR_W-1:0] lfsr_q;
    logic [GAP_W:0]    gap_q, gap_d;
    logic [GAP_W:0]    gap_load;
    logic              gap_expired;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign gap_load    = {1'b0, lfsr_q[GAP_W-1:0]} + GAP_ONE;
    assign gap_expired = (gap_q == GAP_ONE);

    if (GAP_W < LFSR_W) begin : g_lfsr_spare
        logic lfsr_unused;
        assign lfsr_unused = ^lfsr_q[LFSR_W-1:GAP_W];
    end
`else
    logic [15:0] cfg_unused;
    assign cfg_unused = SEED ^ 16'(GAP_W);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= KEY_IDLE;
            done_q  <= 1'b0;
            win_q   <= '0;
            hold_q  <= '0;
`ifdef KEY_BOUNCE_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            done_q  <= done_d;
            win_q   <= win_d;
            hold_q  <= hold_d;
`ifdef KEY_BOUNCE_EN
            gap_q   <= gap_d;
`endif
        end
    end

    // PRESS and RELEASE share one window engine; only the settled level differs.
    assign win_level = (state_q == PRESS) ? KEY_PRESSED : KEY_IDLE;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        done_d  = 1'b0;
        win_d   = win_q;
        hold_d  = hold_q;
`ifdef KEY_BOUNCE_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE: begin
                key_d = KEY_IDLE;
                if (req_valid) begin
                    state_d = PRESS;
                    key_d   = KEY_PRESSED;
                    win_d   = '0;
                    hold_d  = (req_hold == '0) ? HOLD_ONE : req_hold;
`ifdef KEY_BOUNCE_EN
                    gap_d   = gap_load;
`endif
                end
            end
            PRESS, RELEASE: begin
                if (win_q == WIN_LAST) begin
                    key_d = win_level;
                    win_d = '0;
                    if (state_q == PRESS) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    win_d = win_q + WIN_ONE;
`ifdef KEY_BOUNCE_EN
                    gap_d = gap_expired ? gap_load : (gap_q - GAP_ONE);
`endif
                    // The register lands on the settled level in the last window cycle.
                    if (win_q == WIN_PEN) begin
                        key_d = win_level;
                    end
`ifdef KEY_BOUNCE_EN
                    else if (gap_expired) begin
                        key_d = ~key_q;
                    end
`endif
                end
            end
            HOLD: begin
                key_d = KEY_PRESSED;
                if (hold_q == HOLD_ONE) begin
                    state_d = RELEASE;
                    key_d   = KEY_IDLE;
                    win_d   = '0;
`ifdef KEY_BOUNCE_EN
                    gap_d   = gap_load;
`endif
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                key_d   = KEY_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign key_out   = key_q;
    assign done      = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed self-checking bench for key_bounce_gen (BOUNCE_CYC=100, GAP_W=4).
// Edge-count expectations follow KEY_BOUNCE_EN.
module tb_key_bounce_gen;

    localparam int BC  = 100;
    localparam int GW  = 4;
    localparam int HW  = 24;
    localparam int FILT = 101;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b1;
    logic [HW-1:0] req_hold = 24'd5;
    logic          req_ready;
    logic          key_out;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    key_bounce_gen #(
        .BOUNCE_CYC (BC),
        .GAP_W      (GW),
        .HOLD_W     (HW),
        .SEED       (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_hold  (req_hold),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Called at a negedge while idle; returns at the negedge of the first PRESS cycle.
    task automatic accept(input logic [HW-1:0] h);
        req_hold  = h;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({key_out, req_ready, busy, done} !== 4'b1100) begin
                bad++;
                $display("[TB] FAIL reset_cycle%0d: got key/ready/busy/done=%b required 1100", i, {key_out, req_ready, busy, done});
            end
        end
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({key_out, req_ready, busy, done} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL reset_release: got key/ready/busy/done=%b required 1100", {key_out, req_ready, busy, done});
        end
    endtask

    task automatic test_press_release();
        int prev, e_press, e_hold, e_rel, first_done, done_cnt;
        logic low_ok;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pr_ready_idle: got %b required 1", req_ready);
        end
        accept(24'd50);
        prev = 1; e_press = 0; e_hold = 0; e_rel = 0; first_done = 0; done_cnt = 0; low_ok = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            if (k > 1) @(negedge clk);
            if (int'(key_out) != prev) begin
                if (k <= 100) e_press++;
                else if (k <= 150) e_hold++;
                else if (k <= 250) e_rel++;
            end
            prev = int'(key_out);
            if (k == 1) begin
                total++;
                if (key_out !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL pr_first_press: got key=%b busy=%b required key=0 busy=1", key_out, busy);
                end
            end
            if (k >= 100 && k <= 150 && key_out !== 1'b0) low_ok = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
            if (k == 251) begin
                total++;
                if (key_out !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL pr_done_cycle: got key=%b busy=%b ready=%b required 1 0 1", key_out, busy, req_ready);
                end
            end
        end
        total++;
        if (low_ok !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pr_hold_low: key_out not 0 throughout T+100..T+150 (got %b required 1)", low_ok);
        end
        total++;
        if (first_done != 251) begin
            bad++;
            $display("[TB] FAIL pr_done_time: got %0d required 251", first_done);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("[TB] FAIL pr_done_width: got %0d done cycles required 1", done_cnt);
        end
        total++;
        if (e_hold != 0) begin
            bad++;
            $display("[TB] FAIL pr_hold_edges: got %0d required 0", e_hold);
        end
`ifdef KEY_BOUNCE_EN
        total++;
        if (e_press < 4) begin
            bad++;
            $display("[TB] FAIL pr_press_edges: got %0d required >=4", e_press);
        end
        total++;
        if (e_rel < 4) begin
            bad++;
            $display("[TB] FAIL pr_release_edges: got %0d required >=4", e_rel);
        end
`else
        total++;
        if (e_press != 1) begin
            bad++;
            $display("[TB] FAIL pr_press_edges: got %0d required 1", e_press);
        end
        total++;
        if (e_rel != 1) begin
            bad++;
            $display("[TB] FAIL pr_release_edges: got %0d required 1", e_rel);
        end
`endif
    endtask

    task automatic test_zero_hold();
        int first_done;
        first_done = 0;
        @(negedge clk);
        accept(24'd0);
        for (int k = 1; k <= 210; k++) begin
            if (k > 1) @(negedge clk);
            if (done === 1'b1 && first_done == 0) first_done = k;
            if (k == 100 || k == 101) begin
                total++;
                if (key_out !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL zh_low_k%0d: got %b required 0", k, key_out);
                end
            end
            if (k == 102) begin
                total++;
                if (key_out !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL zh_release_start: got %b required 1", key_out);
                end
            end
        end
        total++;
        if (first_done != 202) begin
            bad++;
            $display("[TB] FAIL zh_done_time: got %0d required 202", first_done);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        d1 = 0; d2 = 0;
        @(negedge clk);
        req_hold  = 24'd50;
        req_valid = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 520; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 100) begin
                total++;
                if (req_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL b2b_busy: got ready=%b busy=%b required 0 1", req_ready, busy);
                end
            end
            if (done === 1'b1) begin
                if (d1 == 0) begin
                    d1 = k;
                    total++;
                    if (req_ready !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL b2b_ready_at_done: got %b required 1", req_ready);
                    end
                end else if (d2 == 0) begin
                    d2 = k;
                    req_valid = 1'b0;
                end
            end
            if (d2 != 0 && k == d2 + 2) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL b2b_idle_after: got busy=%b required 0", busy);
                end
            end
        end
        req_valid = 1'b0;
        total++;
        if (d1 != 251) begin
            bad++;
            $display("[TB] FAIL b2b_first_done: got %0d required 251", d1);
        end
        total++;
        if (d2 - d1 != 251) begin
            bad++;
            $display("[TB] FAIL b2b_spacing: got %0d required 251", d2 - d1);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic clean;
        clean = 1'b1;
        @(negedge clk);
        accept(24'd50);
        for (int k = 2; k <= 120; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({key_out, req_ready, busy, done} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL rmh_after_reset: got key/ready/busy/done=%b required 1100", {key_out, req_ready, busy, done});
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || key_out !== 1'b1 || busy !== 1'b0) clean = 1'b0;
        end
        total++;
        if (clean !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rmh_stays_idle: got %b required 1", clean);
        end
    endtask

    task automatic test_debounce();
        logic deb;
        int cnt, presses, releases;
        deb = 1'b1; cnt = 0; presses = 0; releases = 0;
        @(negedge clk);
        accept(24'd200);
        for (int k = 1; k <= 560; k++) begin
            if (k > 1) @(negedge clk);
            if (key_out !== deb) begin
                cnt++;
                if (cnt >= FILT) begin
                    deb = key_out;
                    cnt = 0;
                    if (deb === 1'b0) presses++;
                    else releases++;
                end
            end else begin
                cnt = 0;
            end
        end
        total++;
        if (presses != 1) begin
            bad++;
            $display("[TB] FAIL deb_presses: got %0d required 1", presses);
        end
        total++;
        if (releases != 1) begin
            bad++;
            $display("[TB] FAIL deb_releases: got %0d required 1", releases);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_zero_hold();
        test_back_to_back();
        test_reset_mid_hold();
        test_debounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
